// File: rtl/asmcvd_xp_sync.sv
// -----------------------------------------------------------------------------
// asmcvd_xp_sync
//   Two-lane operand datapath on a single clock.
//   - Add lane: full rate. The registered sum of the registered operands,
//     wrapping modulo 2^WIDTH.
//   - Multiply lane: half rate, driven by a clock-enable rather than a second
//     clock. It holds the low WIDTH bits of the product of the registered
//     operands and loads only on edges where the phase bit is 1.
//   Both lanes see the same input registers. The multiply lane therefore picks
//   up only the pairs sampled on even edges (E0, E2, ...) after reset release.
//
// Ports
//   clk_100meg  in   1      sole clock, rising edge
//   rst_i       in   1      synchronous reset, active high
//   operand_1   in   WIDTH  first operand, sampled every edge
//   operand_2   in   WIDTH  second operand, sampled every edge
//   result      out  WIDTH  registered sum, updates every edge
//   result_2    out  WIDTH  registered product, updates every second edge
// -----------------------------------------------------------------------------
module asmcvd_xp_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk_100meg,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] operand_1,
   input  logic [WIDTH-1:0] operand_2,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_2
);

   logic [WIDTH-1:0] op1_q, op1_d;
   logic [WIDTH-1:0] op2_q, op2_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_2_q, result_2_d;
   logic             phase_q, phase_d;

   logic [WIDTH-1:0] sum_w;
   logic [WIDTH-1:0] prod_w;

   // Both results are truncated to WIDTH bits by the width of the target.
   // The sum wraps, and the product keeps only its low bits.
   always_comb begin
      sum_w  = op1_q + op2_q;
      prod_w = op1_q * op2_q;
   end

   always_comb begin
      op1_d      = operand_1;
      op2_d      = operand_2;
      result_d   = sum_w;
      result_2_d = result_2_q;
      phase_d    = ~phase_q;
      // The phase value before the edge is the half-rate enable.
      if (phase_q) begin
         result_2_d = prod_w;
      end
   end

   always_ff @(posedge clk_100meg) begin
      if (rst_i) begin
         op1_q      <= '0;
         op2_q      <= '0;
         result_q   <= '0;
         result_2_q <= '0;
         phase_q    <= 1'b0;
      end else begin
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         result_q   <= result_d;
         result_2_q <= result_2_d;
         phase_q    <= phase_d;
      end
   end

   assign result   = result_q;
   assign result_2 = result_2_q;

endmodule

// File: tb/tb_asmcvd_xp_sync.sv
module tb_asmcvd_xp_sync;

   logic       clk_100meg;
   logic       rst_i;
   logic [7:0] operand_1;
   logic [7:0] operand_2;
   logic [7:0] result;
   logic [7:0] result_2;

   int n_cmp;
   int n_err;

   // Reference model state.
   // edge_n counts edges since reset release: 0 is E0, and -1 means the last
   // edge was a reset edge.
   int         edge_n;
   logic [7:0] prev_a, prev_b;
   logic [7:0] m_res, m_r2;

   asmcvd_xp_sync #(.WIDTH(8)) u_dut (
      .clk_100meg (clk_100meg),
      .rst_i      (rst_i),
      .operand_1  (operand_1),
      .operand_2  (operand_2),
      .result     (result),
      .result_2   (result_2)
   );

   initial clk_100meg = 1'b0;
   always #5 clk_100meg = ~clk_100meg;

   // Drives one edge and advances the reference model.
   // The model works from edge indices: the sum after edge n comes from the
   // pair driven on edge n-1, and the product is refreshed after each odd edge
   // from the pair driven on the edge before it.
   task automatic tick(input logic [7:0] a, input logic [7:0] b, input logic r);
      @(negedge clk_100meg);
      operand_1 = a;
      operand_2 = b;
      rst_i     = r;
      @(posedge clk_100meg);
      if (r) begin
         edge_n = -1;
         m_res  = 8'd0;
         m_r2   = 8'd0;
         prev_a = 8'd0;
         prev_b = 8'd0;
      end else begin
         edge_n = edge_n + 1;
         if (edge_n == 0) m_res = 8'd0;
         else             m_res = 8'((int'(prev_a) + int'(prev_b)) % 256);
         if ((edge_n % 2) == 1)
            m_r2 = 8'((int'(prev_a) * int'(prev_b)) % 256);
         prev_a = a;
         prev_b = b;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         tick(8'($urandom), 8'($urandom), 1'b1);
         n_cmp++;
         if (result !== 8'd0) begin
            n_err++;
            $display("FAIL reset_result: got %0h expected 0", result);
         end
         n_cmp++;
         if (result_2 !== 8'd0) begin
            n_err++;
            $display("FAIL reset_result_2: got %0h expected 0", result_2);
         end
         n_cmp++;
         if (u_dut.phase_q !== 1'b0) begin
            n_err++;
            $display("FAIL reset_phase: got %0b expected 0", u_dut.phase_q);
         end
      end
   endtask

   task automatic test_stream();
      logic [7:0] ia [5];
      logic [7:0] ib [5];
      logic [7:0] es [5];
      logic [7:0] ep [5];
      ia = '{8'd3, 8'd2, 8'd8, 8'd1, 8'd0};
      ib = '{8'd5, 8'd7, 8'd8, 8'd4, 8'd0};
      es = '{8'd0, 8'd8, 8'd9, 8'd16, 8'd5};
      ep = '{8'd0, 8'd15, 8'd15, 8'd64, 8'd64};
      tick(8'd0, 8'd0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick(ia[k], ib[k], 1'b0);
         n_cmp++;
         if (result !== es[k]) begin
            n_err++;
            $display("FAIL stream_sum E%0d: got %0d expected %0d", k, result, es[k]);
         end
         n_cmp++;
         if (result_2 !== ep[k]) begin
            n_err++;
            $display("FAIL stream_prod E%0d: got %0d expected %0d", k, result_2, ep[k]);
         end
      end
   endtask

   task automatic test_boundaries();
      logic [7:0] ia [6];
      logic [7:0] ib [6];
      logic [7:0] es [6];
      logic [7:0] ep [6];
      // E0 FF+01 wraps. E2 10*10 truncates. E4 has a zero operand.
      ia = '{8'hFF, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01};
      ib = '{8'h01, 8'h00, 8'h10, 8'h05, 8'h37, 8'h01};
      es = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h05, 8'h37};
      ep = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
      tick(8'd0, 8'd0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         tick(ia[k], ib[k], 1'b0);
         n_cmp++;
         if (result !== es[k]) begin
            n_err++;
            $display("FAIL boundary_sum E%0d: got %0h expected %0h", k, result, es[k]);
         end
         n_cmp++;
         if (result_2 !== ep[k]) begin
            n_err++;
            $display("FAIL boundary_prod E%0d: got %0h expected %0h", k, result_2, ep[k]);
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) tick(8'($urandom_range(2, 9)), 8'($urandom_range(2, 9)), 1'b0);
      tick(8'd9, 8'd9, 1'b1);
      n_cmp++;
      if (result !== 8'd0 || result_2 !== 8'd0) begin
         n_err++;
         $display("FAIL midreset_clear: got %0h/%0h expected 0/0", result, result_2);
      end
      tick(8'd4, 8'd5, 1'b0);
      n_cmp++;
      if (result !== 8'd0 || result_2 !== 8'd0) begin
         n_err++;
         $display("FAIL midreset_E0: got %0h/%0h expected 0/0", result, result_2);
      end
      tick(8'd6, 8'd7, 1'b0);
      n_cmp++;
      if (result !== 8'd9 || result_2 !== 8'd20) begin
         n_err++;
         $display("FAIL midreset_E1: got %0d/%0d expected 9/20", result, result_2);
      end
      tick(8'd1, 8'd1, 1'b0);
      n_cmp++;
      if (result !== 8'd13 || result_2 !== 8'd20) begin
         n_err++;
         $display("FAIL midreset_E2: got %0d/%0d expected 13/20", result, result_2);
      end
   endtask

   task automatic test_random(input int cycles, input int lo, input int hi);
      tick(8'd0, 8'd0, 1'b1);
      for (int i = 0; i < cycles; i++) begin
         tick(8'($urandom_range(hi, lo)), 8'($urandom_range(hi, lo)), 1'b0);
         n_cmp++;
         if (result !== m_res) begin
            n_err++;
            $display("FAIL random_sum cyc %0d: got %0h expected %0h", i, result, m_res);
         end
         n_cmp++;
         if (result_2 !== m_r2) begin
            n_err++;
            $display("FAIL random_prod cyc %0d: got %0h expected %0h", i, result_2, m_r2);
         end
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      edge_n    = -1;
      prev_a    = 8'd0;
      prev_b    = 8'd0;
      m_res     = 8'd0;
      m_r2      = 8'd0;
      rst_i     = 1'b1;
      operand_1 = 8'd0;
      operand_2 = 8'd0;
      test_reset();
      test_stream();
      test_boundaries();
      test_mid_reset();
      test_random(200, 1, 8);
      test_random(100, 0, 255);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
